// File: rtl/qupls_writeback_arbiter_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
// Sources queue results; the arbiter drives NWP register-file write ports.
package qupls_writeback_arbiter_pkg;

    localparam int NSRC   = 8;
    localparam int NWP    = 4;
    localparam int WID    = 64;
    localparam int RBIT   = 8;
    localparam int QDEPTH = 2;

    localparam int SRCW  = $clog2(NSRC);
    localparam int QPW   = $clog2(QDEPTH);
    localparam int CNTW  = QPW + 1;
    localparam int PORTW = $clog2(NWP) + 1;

    typedef logic [RBIT:0]  pregno_t;
    typedef logic [WID-1:0] value_t;

endpackage

// File: rtl/qupls_writeback_arbiter_wb_fifo.sv
// Per-source result queue: preg/data pairs, head always visible.
// Pointers wrap naturally; count is one bit wider than the pointers.
module qupls_wb_fifo
    import qupls_writeback_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  pregno_t         push_preg,
    input  value_t          push_data,
    output pregno_t         head_preg,
    output value_t          head_data,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);

    pregno_t        preg_mem [QDEPTH];
    value_t         data_mem [QDEPTH];
    logic [QPW-1:0] wptr;
    logic [QPW-1:0] rptr;
    logic           do_push;
    logic           do_pop;

    assign full      = (count == CNTW'(QDEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_preg = preg_mem[rptr];
    assign head_data = data_mem[rptr];

    // Pointer and occupancy tracking; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Entry storage; contents are meaningless while empty so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            preg_mem[wptr] <= push_preg;
            data_mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/qupls_writeback_arbiter.sv
// Writeback arbiter: rotating-priority grant of queue heads to write
// ports, deferring same-preg conflicts and dropping preg-0 results.
module qupls_writeback_arbiter
    import qupls_writeback_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC-1:0]          src_valid,
    output logic [NSRC-1:0]          src_ready,
    input  pregno_t [NSRC-1:0]       src_preg,
    input  value_t  [NSRC-1:0]       src_data,
    output logic [NWP-1:0]           wr,
    output pregno_t [NWP-1:0]        wa,
    output value_t  [NWP-1:0]        wd,
    output logic                     busy
);

    pregno_t [NSRC-1:0]        head_preg;
    value_t  [NSRC-1:0]        head_data;
    logic [NSRC-1:0][CNTW-1:0] cnt;
    logic [NSRC-1:0]           full;
    logic [NSRC-1:0]           empty;
    logic [NSRC-1:0]           push;
    logic [NSRC-1:0]           pop;

    logic [SRCW-1:0]           rr;
    logic [SRCW-1:0]           nxt_rr;
    logic [SRCW-1:0]           s;
    logic [PORTW-1:0]          n;
    logic                      hit;
    logic                      any;
    logic [NWP-1:0]            gv;
    pregno_t [NWP-1:0]         gp;
    value_t  [NWP-1:0]         gd;
    logic                      queued;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_ready[g] = !full[g] && !rst && !flush;
        assign push[g]      = src_valid[g] && src_ready[g];

        qupls_wb_fifo u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (push[g]),
            .pop       (pop[g]),
            .push_preg (src_preg[g]),
            .push_data (src_data[g]),
            .head_preg (head_preg[g]),
            .head_data (head_data[g]),
            .count     (cnt[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    // Rotating scan from rr: drop preg 0, defer same-preg heads, fill ports.
    always_comb begin
        pop    = '0;
        gv     = '0;
        gp     = '0;
        gd     = '0;
        nxt_rr = rr;
        any    = 1'b0;
        n      = '0;
        s      = '0;
        hit    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            s = rr + SRCW'(i);
            if (n < PORTW'(NWP) && !empty[s]) begin
                if (head_preg[s] == '0) begin
                    pop[s] = 1'b1;
                    nxt_rr = s + 1'b1;
                    any    = 1'b1;
                end else begin
                    hit = 1'b0;
                    for (int k = 0; k < NWP; k++)
                        if (PORTW'(k) < n && gp[k] == head_preg[s])
                            hit = 1'b1;
                    if (!hit) begin
                        for (int k = 0; k < NWP; k++) begin
                            if (PORTW'(k) == n) begin
                                gv[k] = 1'b1;
                                gp[k] = head_preg[s];
                                gd[k] = head_data[s];
                            end
                        end
                        pop[s] = 1'b1;
                        nxt_rr = s + 1'b1;
                        any    = 1'b1;
                        n      = n + 1'b1;
                    end
                end
            end
        end
    end

    // Register grants onto the write ports; idle ports keep wa/wd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            wa <= '0;
            wd <= '0;
            rr <= '0;
        end else if (flush) begin
            wr <= '0;
        end else begin
            wr <= gv;
            for (int k = 0; k < NWP; k++) begin
                if (gv[k]) begin
                    wa[k] <= gp[k];
                    wd[k] <= gd[k];
                end
            end
            if (any)
                rr <= nxt_rr;
        end
    end

    // Busy while anything is queued or a write is on the ports.
    always_comb begin
        queued = 1'b0;
        for (int g = 0; g < NSRC; g++)
            if (cnt[g] != '0)
                queued = 1'b1;
        busy = queued || (|wr);
    end

endmodule

// File: tb/tb_qupls_writeback_arbiter.sv
// Directed bench for the writeback arbiter: a cycle table for grant,
// conflict and flush behaviour plus hand sequences for reset and backpressure.
module tb_qupls_writeback_arbiter;
    import qupls_writeback_arbiter_pkg::*;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [NSRC-1:0]    src_valid;
    logic [NSRC-1:0]    src_ready;
    pregno_t [NSRC-1:0] src_preg;
    value_t  [NSRC-1:0] src_data;
    logic [NWP-1:0]     wr;
    pregno_t [NWP-1:0]  wa;
    value_t  [NWP-1:0]  wd;
    logic               busy;

    int errors = 0;
    int checks = 0;

    qupls_writeback_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_preg  (src_preg),
        .src_data  (src_data),
        .wr        (wr),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       valid;
        logic             flush;
        logic             same;
        pregno_t          base;
        logic [3:0]       xwr;
        logic             chkwa;
        logic [3:0][8:0]  xwa;
        logic [3:0][3:0]  xsrc;
        logic             xbusy;
        logic [7:0]       xready;
        logic [2:0]       xrr;
    } vec_t;

    vec_t tv [11];

    function automatic vec_t mk(logic [7:0] v, logic f, logic sm,
                                pregno_t b, logic [3:0] xw, logic cw,
                                logic [35:0] xa, logic [15:0] xs,
                                logic xb, logic [7:0] xr, logic [2:0] xq);
        vec_t r;
        r.valid  = v;
        r.flush  = f;
        r.same   = sm;
        r.base   = b;
        r.xwr    = xw;
        r.chkwa  = cw;
        r.xwa    = xa;
        r.xsrc   = xs;
        r.xbusy  = xb;
        r.xready = xr;
        r.xrr    = xq;
        return r;
    endfunction

    function automatic value_t dat(int s, pregno_t p);
        return 64'hA500_0000_0000_0000 | (64'(s) << 48) | 64'(p);
    endfunction

    function automatic value_t bp(int s, int c);
        return 64'hB000_0000_0000_0000 | (64'(s) << 8) | 64'(c);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_unique();
        logic dup;
        dup = 1'b0;
        for (int j = 0; j < NWP; j++)
            for (int k = j + 1; k < NWP; k++)
                if (wr[j] && wr[k] && wa[j] == wa[k])
                    dup = 1'b1;
        chk("unique_wa", 64'(dup), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(vec_t v, int idx);
        string nm;
        src_valid = v.valid;
        flush     = v.flush;
        for (int s = 0; s < NSRC; s++) begin
            src_preg[s] = v.same ? v.base : v.base + pregno_t'(s);
            src_data[s] = dat(s, src_preg[s]);
        end
        if (v.flush) begin
            #1;
            chk($sformatf("row%0d_ready_in_flush", idx), 64'(src_ready), 64'd0);
        end
        step();
        src_valid = '0;
        flush     = 1'b0;
        #1;
        chk($sformatf("row%0d_wr", idx), 64'(wr), 64'(v.xwr));
        chk($sformatf("row%0d_busy", idx), 64'(busy), 64'(v.xbusy));
        chk($sformatf("row%0d_ready", idx), 64'(src_ready), 64'(v.xready));
        chk($sformatf("row%0d_rr", idx), 64'(dut.rr), 64'(v.xrr));
        chk_unique();
        if (v.chkwa) begin
            for (int k = 0; k < NWP; k++) begin
                nm = $sformatf("row%0d_wa%0d", idx, k);
                chk(nm, 64'(wa[k]), 64'(v.xwa[k]));
                nm = $sformatf("row%0d_wd%0d", idx, k);
                chk(nm, wd[k], dat(int'(v.xsrc[k]), v.xwa[k]));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        src_preg  = '0;
        src_data  = '0;

        // Oversubscription: 8 distinct heads, rr 0 -> 4 -> 0.
        tv[0]  = mk(8'hFF, 0, 0, 9'h040, 4'h0, 0, '0, '0,
                    1, 8'hFF, 3'd0);
        tv[1]  = mk(8'h00, 0, 0, 9'h000, 4'hF, 1,
                    {9'h043, 9'h042, 9'h041, 9'h040}, 16'h3210,
                    1, 8'hFF, 3'd4);
        tv[2]  = mk(8'h00, 0, 0, 9'h000, 4'hF, 1,
                    {9'h047, 9'h046, 9'h045, 9'h044}, 16'h7654,
                    1, 8'hFF, 3'd0);
        tv[3]  = mk(8'h00, 0, 0, 9'h000, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h044}, 16'h7654,
                    0, 8'hFF, 3'd0);
        // Conflict: sources 1 and 2 both target preg 0x010.
        tv[4]  = mk(8'h06, 0, 1, 9'h010, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h044}, 16'h7654,
                    1, 8'hFF, 3'd0);
        tv[5]  = mk(8'h00, 0, 0, 9'h000, 4'h1, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7651,
                    1, 8'hFF, 3'd2);
        tv[6]  = mk(8'h00, 0, 0, 9'h000, 4'h1, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7652,
                    1, 8'hFF, 3'd3);
        tv[7]  = mk(8'h00, 0, 0, 9'h000, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7652,
                    0, 8'hFF, 3'd3);
        // Flush with two queued results and a push in the flush cycle.
        tv[8]  = mk(8'h03, 0, 0, 9'h030, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7652,
                    1, 8'hFF, 3'd3);
        tv[9]  = mk(8'h04, 1, 0, 9'h030, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7652,
                    0, 8'hFF, 3'd3);
        tv[10] = mk(8'h00, 0, 0, 9'h000, 4'h0, 1,
                    {9'h047, 9'h046, 9'h045, 9'h010}, 16'h7652,
                    0, 8'hFF, 3'd3);

        // Reset state while rst is held, then after release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(src_ready), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_wa0", 64'(wa[0]), 64'd0);
        chk("rst_wd0", wd[0], 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(src_ready), 64'hFF);
        chk("rel_wr", 64'(wr), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 11; i++)
            apply(tv[i], i);

        // Single write from source 3; rr starts at 3 here.
        src_valid[3] = 1'b1;
        src_preg[3]  = 9'h025;
        src_data[3]  = 64'h0000_0000_DEAD_BEEF;
        step();
        src_valid = '0;
        chk("sw_e0_wr", 64'(wr), 64'd0);
        chk("sw_e0_busy", 64'(busy), 64'd1);
        step();
        chk("sw_e1_wr", 64'(wr), 64'h1);
        chk("sw_e1_wa", 64'(wa[0]), 64'h025);
        chk("sw_e1_wd", wd[0], 64'h0000_0000_DEAD_BEEF);
        chk("sw_e1_busy", 64'(busy), 64'd1);
        chk("sw_e1_rr", 64'(dut.rr), 64'd4);
        step();
        chk("sw_e2_wr", 64'(wr), 64'd0);
        chk("sw_e2_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of traffic.
        src_valid[0] = 1'b1;
        src_preg[0]  = 9'h050;
        src_data[0]  = 64'h50;
        step();
        src_preg[0]  = 9'h051;
        src_data[0]  = 64'h51;
        step();
        src_valid = '0;
        chk("mr_wr", 64'(wr), 64'h1);
        chk("mr_wa", 64'(wa[0]), 64'h050);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_wr", 64'(wr), 64'd0);
        chk("mr_async_wa", 64'(wa[0]), 64'd0);
        chk("mr_async_busy", 64'(busy), 64'd0);
        chk("mr_async_ready", 64'(src_ready), 64'd0);
        chk("mr_async_rr", 64'(dut.rr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mr_lost_wr", 64'(wr), 64'd0);
        chk("mr_lost_busy", 64'(busy), 64'd0);

        // Preg 0 drop and backpressure on source 6; rr starts at 0.
        for (int s = 0; s < NSRC; s++) begin
            src_preg[s] = 9'h020 + pregno_t'(s);
            src_data[s] = bp(s, 0);
        end
        src_preg[5] = '0;
        src_valid   = 8'h6F;
        step();
        chk("bp_e0_wr", 64'(wr), 64'd0);
        chk("bp_e0_ready", 64'(src_ready), 64'hFF);
        for (int s = 0; s < NSRC; s++)
            src_data[s] = bp(s, 1);
        src_valid = 8'h4F;
        step();
        chk("bp_e1_wr", 64'(wr), 64'hF);
        for (int k = 0; k < NWP; k++) begin
            chk($sformatf("bp_e1_wa%0d", k), 64'(wa[k]), 64'(9'h020 + k));
            chk($sformatf("bp_e1_wd%0d", k), wd[k], bp(k, 0));
        end
        chk("bp_e1_ready", 64'(src_ready), 64'hBF);
        chk("bp_e1_rr", 64'(dut.rr), 64'd4);
        src_data[6] = bp(6, 2);
        src_valid   = 8'h40;
        step();
        src_valid = '0;
        chk("bp_e2_wr", 64'(wr), 64'hF);
        chk("bp_e2_wa0", 64'(wa[0]), 64'h026);
        chk("bp_e2_wd0", wd[0], bp(6, 0));
        for (int k = 1; k < NWP; k++) begin
            chk($sformatf("bp_e2_wa%0d", k), 64'(wa[k]), 64'(9'h020 + k - 1));
            chk($sformatf("bp_e2_wd%0d", k), wd[k], bp(k - 1, 1));
        end
        chk_unique();
        chk("bp_e2_ready", 64'(src_ready), 64'hFF);
        chk("bp_e2_rr", 64'(dut.rr), 64'd3);
        step();
        chk("bp_e3_wr", 64'(wr), 64'h3);
        chk("bp_e3_wa0", 64'(wa[0]), 64'h023);
        chk("bp_e3_wd0", wd[0], bp(3, 1));
        chk("bp_e3_wa1", 64'(wa[1]), 64'h026);
        chk("bp_e3_wd1", wd[1], bp(6, 1));
        chk("bp_e3_rr", 64'(dut.rr), 64'd7);
        step();
        chk("bp_e4_wr", 64'(wr), 64'd0);
        chk("bp_e4_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qupls_writeback_arbiter.md
# qupls_writeback_arbiter

Collects completed results from functional units and drives the write ports of the physical register file. Each source has a small per-source queue. Every cycle the block grants up to NWP queue heads with rotating priority, never two writes to the same physical register in one cycle, and registers the chosen writes onto the write-port buses. It sits between the functional-unit result buses and the multi-write-port register file, with its LVT.

## Interface
- NSRC, 8, number of result sources (functional units)
- NWP, 4, number of register-file write ports driven
- WID, 64, result data width
- RBIT, 8, physical register number MSB (pregno_t is RBIT+1 bits)
- QDEPTH, 2, entries per source queue (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of all queued results
- src_valid  in  NSRC  result present on source s
- src_ready  out  NSRC  source s queue can accept
- src_preg  in  NSRC×pregno_t  destination physical register
- src_data  in  NSRC×value_t  result value
- wr  out  NWP  write-port enable (feeds register file wr/we)
- wa  out  NWP×pregno_t  write-port address
- wd  out  NWP×value_t  write-port data
- busy  out  1  any queue non-empty or any wr asserted

## Operation
- Accept on src_valid[s] && src_ready[s] at a rising edge. The entry is pushed to queue s.
- src_ready[s] = (count[s] != QDEPTH) && !rst && !flush. There is no pop-credit lookahead: a full queue deasserts ready even if it is popped that cycle.
- A pushed entry reaches the head at the next cycle. There is no bypass from the source straight to a write port.
- Selection is combinational over the queue heads. It scans sources starting at rr, wrapping modulo NSRC, and stops after NWP grants.
  - A head with preg == 0 is popped but takes no port and produces no write.
  - A head whose preg equals a preg already granted this cycle is skipped and stays queued (conflict deferral).
  - Otherwise the head is granted to the lowest free port index, k-th grant → port k.
- Granted heads are popped at the edge. wr[k]/wa[k]/wd[k] are registered from the grants at that same edge. Ports with no grant get wr[k]=0, while wa/wd hold their previous values.
- rr update: rr ← (index of last granted or dropped source + 1) mod NSRC. If nothing was granted or dropped, rr is unchanged.
- flush: at the edge, all counts go to 0, wr goes to 0, and rr is unchanged. Handshakes in the flush cycle are ignored.
- Queue pointers are log2(QDEPTH) bits wrapping naturally. count is log2(QDEPTH)+1 bits.

## Timing
- Reset values: wr=0, wa=0, wd=0, src_ready=0 while rst is high and all-ones after release, busy=0, rr=0, all counts 0.
- Latency: accept at edge E0 → head visible in cycle E0..E1 → wr asserted after E1 → register file writes at E2. Minimum is 1 cycle from accept to wr.
- Throughput: NWP writes per cycle maximum, and 1 entry per source per cycle.
- Simultaneous push and pop on a non-full queue: both take effect and count is unchanged.
- Reset asserted mid-operation: queued results are lost and outputs go to their reset values immediately.
- No combinational path from src_* to wr/wa/wd. src_ready depends only on registered count, rst and flush.

## Structure
- QuplsPkg supplies pregno_t, value_t, and the NWP/NSRC defaults if made global. No new package types are needed.
- Sub-module qupls_wb_fifo holds one per-source queue: push, pop, head preg/data, count, and full/empty. It is instantiated NSRC times in a generate.
- The arbiter scan, the conflict compare (NWP×NSRC preg comparators) and the output registers stay in the top module.

## Test plan
- Reset release: after rst drops, src_ready=8'hFF, wr=0, busy=0.
- Single write: source 3 sends preg 9'h025 / data 64'hDEAD_BEEF at E0. Then wr=4'b0001, wa[0]=9'h025, wd[0]=DEAD_BEEF after E1, and busy falls after E2.
- Oversubscription: all 8 sources are valid in one cycle with distinct pregs and rr=0. Sources 0–3 go to ports 0–3 after E1 and sources 4–7 after E2. rr goes to 4, then 0.
- Conflict: sources 1 and 2 both target preg 9'h010 in the same cycle. Source 1 is written first and source 2 one cycle later. No cycle has two wr bits with equal wa.
- Preg 0 and backpressure: source 5 sends preg 0, which is popped with no wr. Source 6 is held valid while arbitration is starved by 4 higher-priority continuous sources. Its ready drops after 2 accepts and no data is lost.
- Flush: with queues partially full, a 1-cycle flush gives wr=0 next cycle, busy=0, and no subsequent writes of the pre-flush data.
